// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the two-port data memory arbiter: CPU port A, display/debug
// port B and the single-ported data memory side.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  // port A (CPU)
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  // port B (display/debug)
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  // data memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter view
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // requester/memory view
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter. Port A (CPU) has priority; port B wins a
// contested cycle once it has lost STARVE_LIMIT consecutive cycles. Grants
// are combinational, reads return one cycle later tagged with their owner.
module data_mem_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4   // legal 1..15
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_arbiter_if.slave    bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // read-owner tag encoding
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  logic [3:0] starve_cnt;
  logic [1:0] rd_owner;
  logic       a_win;
  logic       b_win;

  // Pick the winner; reset blanks grants so nothing reaches memory while held.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (!reset) begin
      a_win = bus.a_req && !(bus.b_req && (starve_cnt == LIMIT));
      b_win = bus.b_req && !a_win;
    end
  end

  // Steer the winner's fields onto the memory bus; idle bus is all zeros.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (a_win) begin
      bus.mem_read  = !bus.a_we;
      bus.mem_write = bus.a_we;
      bus.mem_addr  = bus.a_addr;
      bus.mem_wdata = bus.a_wdata;
    end else if (b_win) begin
      bus.mem_read  = !bus.b_we;
      bus.mem_write = bus.b_we;
      bus.mem_addr  = bus.b_addr;
      bus.mem_wdata = bus.b_wdata;
    end
  end

  assign bus.a_gnt = a_win;
  assign bus.b_gnt = b_win;

  // Count consecutive cycles B asked and lost; any B win or idle B clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (bus.b_req && !b_win) begin
      starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Remember who issued this cycle's read so next cycle's data goes only there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner <= OWN_NONE;
    end else if (a_win && !bus.a_we) begin
      rd_owner <= OWN_A;
    end else if (b_win && !bus.b_we) begin
      rd_owner <= OWN_B;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  // Return data to the owner only; the other port sees zero.
  always_comb begin
    bus.a_rvalid = (rd_owner == OWN_A);
    bus.b_rvalid = (rd_owner == OWN_B);
    bus.a_rdata  = bus.a_rvalid ? bus.mem_rdata : '0;
    bus.b_rdata  = bus.b_rvalid ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected grants and
// read returns from a reference model; a negedge monitor pops and compares.
module tb_data_mem_arbiter;
  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int             who;    // 0 none, 1 A, 2 B
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    int             starve; // expected counter value during this cycle
  } gnt_t;

  typedef struct {
    int             who;
    logic [DW-1:0]  data;
    int             due;
  } rd_t;

  gnt_t gnt_q[$];
  rd_t  rd_q[$];
  int   log_win[$];
  bit   log_en = 0;
  bit   mon_en = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   b_lost = 0;           // model: consecutive cycles B was refused
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] ram [64];

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 5) ? 8'h3C : 8'(i * 29 + 7);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data memory: synchronous write, registered read.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
    end else begin
      if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_read) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Monitor: pops one grant expectation per cycle and any read return due now.
  always @(negedge clk) begin : mon
    gnt_t g;
    rd_t  r;
    bit   rv;
    if (mon_en) begin
      if (gnt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL gnt_q_underflow: got empty queue expected an entry (cycle %0d)", cyc);
      end else begin
        g = gnt_q.pop_front();
        chk("a_gnt", bus.a_gnt, g.who == 1);
        chk("b_gnt", bus.b_gnt, g.who == 2);
        chk("mem_read", bus.mem_read, (g.who != 0) && !g.we);
        chk("mem_write", bus.mem_write, (g.who != 0) && g.we);
        chk("mem_addr", bus.mem_addr, (g.who != 0) ? g.addr : '0);
        chk("mem_wdata", bus.mem_wdata, (g.who != 0) ? g.wdata : '0);
        chk("starve_cnt", dut.starve_cnt, g.starve);
      end
      if (log_en) log_win.push_back(bus.a_gnt ? 1 : (bus.b_gnt ? 2 : 0));
      rv = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      r.who = 0; r.data = '0; r.due = 0;
      if (rv) r = rd_q.pop_front();
      chk("a_rvalid", bus.a_rvalid, rv && r.who == 1);
      chk("b_rvalid", bus.b_rvalid, rv && r.who == 2);
      chk("a_rdata", bus.a_rdata, (rv && r.who == 1) ? r.data : '0);
      chk("b_rdata", bus.b_rdata, (rv && r.who == 2) ? r.data : '0);
    end
  end

  // Drive one cycle's requests and push what the rules say must happen.
  task automatic issue(bit ar, bit aw, logic [AW-1:0] aa, logic [DW-1:0] ad,
                       bit br, bit bw, logic [AW-1:0] ba, logic [DW-1:0] bd,
                       output int win);
    gnt_t g;
    rd_t  r;
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    if (ar && br)  win = (b_lost == LIM) ? 2 : 1;
    else if (ar)   win = 1;
    else if (br)   win = 2;
    else           win = 0;
    g.who = win; g.starve = b_lost;
    g.we    = (win == 2) ? bw : aw;
    g.addr  = (win == 2) ? ba : aa;
    g.wdata = (win == 2) ? bd : ad;
    gnt_q.push_back(g);
    if (win != 0) begin
      if (g.we) begin
        ref_mem[g.addr] = g.wdata;
      end else begin
        r.who = win; r.data = ref_mem[g.addr]; r.due = cyc + 1;
        rd_q.push_back(r);
      end
    end
    if (br && win != 2) b_lost = (b_lost >= LIM) ? LIM : b_lost + 1;
    else b_lost = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    int w;
    for (int i = 0; i < n; i++) begin
      issue(0, 0, 6'd0, 8'd0, 0, 0, 6'd0, 8'd0, w);
      step();
    end
  endtask

  initial begin : stim
    int w;
    bit ap, bp, aw, bw;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    reset = 1'b1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 6'd3; bus.a_wdata = 8'h11;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 6'd4; bus.b_wdata = 8'h22;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state with both ports requesting
    chk("rst_a_gnt", bus.a_gnt, 0);
    chk("rst_b_gnt", bus.b_gnt, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rvalid", bus.b_rvalid, 0);
    chk("rst_starve", dut.starve_cnt, 0);
    step();
    reset = 1'b0;
    mon_en = 1;

    // A-only read of address 5 (holds 0x3C)
    issue(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00, w);
    step();
    // B-only write 0xA5 to address 12
    issue(0, 0, 6'd0, 8'h00, 1, 1, 6'd12, 8'hA5, w);
    step();
    idle(1);

    // both requesting continuously: A,A,A,A,B repeating
    log_en = 1;
    bd = 8'h00; ba = 6'd20;
    for (int i = 0; i < 10; i++) begin
      issue(1, 0, 6'(i), 8'h00, 1, 0, ba, bd, w);
      step();
      chk("starve_seq", dut.starve_cnt, (i % 5 == 4) ? 0 : (i % 5) + 1);
      if (w == 2) ba = 6'(ba + 1);
    end
    log_en = 0;
    for (int i = 0; i < 10; i++)
      chk("grant_pattern", (i < log_win.size()) ? log_win[i] : -1, (i % 5 == 4) ? 2 : 1);

    // A writes 0x7E to 9, B reads 9 next cycle
    issue(1, 1, 6'd9, 8'h7E, 0, 0, 6'd0, 8'h00, w);
    step();
    issue(0, 0, 6'd0, 8'h00, 1, 0, 6'd9, 8'h00, w);
    step();
    // back-to-back reads from both ports
    issue(1, 0, 6'd12, 8'h00, 0, 0, 6'd0, 8'h00, w);
    step();
    issue(0, 0, 6'd0, 8'h00, 1, 0, 6'd5, 8'h00, w);
    step();

    // ten quiet cycles
    idle(10);

    // reset lands between edges after a read grant
    issue(1, 0, 6'd7, 8'h00, 0, 0, 6'd0, 8'h00, w);
    #6;
    mon_en = 0;
    reset = 1'b1;
    #1;
    chk("midrst_a_gnt", bus.a_gnt, 0);
    chk("midrst_mem_read", bus.mem_read, 0);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    chk("midrst_a_rvalid", bus.a_rvalid, 0);
    chk("midrst_a_rdata", bus.a_rdata, 0);
    gnt_q.delete();
    rd_q.delete();
    b_lost = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    step();
    chk("midrst_no_rvalid_a", bus.a_rvalid, 0);
    chk("midrst_no_rvalid_b", bus.b_rvalid, 0);
    bus.a_req = 0; bus.b_req = 0;
    step();
    reset = 1'b0;
    mon_en = 1;
    issue(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00, w);
    step();
    idle(1);

    // randomized traffic with held requests and occasional withdrawal
    ap = 0; bp = 0; aw = 0; bw = 0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 500; i++) begin
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1; aw = 1'($urandom_range(0, 1)); aa = 6'($urandom_range(0, 7)); ad = 8'($urandom);
      end else if (ap && $urandom_range(0, 15) == 0) begin
        ap = 0;
      end
      if (!bp && $urandom_range(0, 3) != 0) begin
        bp = 1; bw = 1'($urandom_range(0, 1)); ba = 6'($urandom_range(0, 7)); bd = 8'($urandom);
      end else if (bp && $urandom_range(0, 31) == 0) begin
        bp = 0;
      end
      issue(ap, aw, aa, ad, bp, bw, ba, bd, w);
      step();
      if (w == 1) ap = 0;
      if (w == 2) bp = 0;
    end
    idle(2);
    mon_en = 0;
    chk("rd_q_drained", rd_q.size(), 0);
    chk("gnt_q_drained", gnt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
